// File: rtl/img_uart_loader_if.sv
// RAM write port of the image loader: one single-cycle write strobe with
// address and 12-bit pixel, no back-pressure.
interface img_uart_loader_if;
  logic        we;
  logic [13:0] addr;
  logic [11:0] wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/img_uart_loader.sv
// UART image loader: receives a header byte followed by PIX_NUM pixels sent as
// {0,R} / {G,B} byte pairs and writes them into the VGA image RAM.
module img_uart_loader #(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 115200,
  parameter int         PIX_NUM  = 16384,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         TIMEOUT  = 1_000_000
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_rxd,
  img_uart_loader_if.master O_ram,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_err
);

  // CLK_FREQ/BAUD must be at least 4 so the half-bit start check is meaningful.
  localparam int                CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int                CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int                TMR_W        = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX      = TMR_W'(TIMEOUT);
  localparam logic [13:0]       ADDR_LAST    = 14'(PIX_NUM - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {F_IDLE, F_HI, F_LO, F_ABORT} frame_state_e;

  // ---------------------------------------------------------------- RX front end
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= I_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid, rx_ferr;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Returning to idle at the stop mid-point lets a back-to-back start bit be caught.
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid   = rxd_sync_q;
          rx_ferr    = !rxd_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- frame FSM
  frame_state_e     state_q, state_d;
  logic [13:0]      pix_addr_q, pix_addr_d;
  logic [3:0]       red_q, red_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             we_q, we_d;
  logic [13:0]      wr_addr_q, wr_addr_d;
  logic [11:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= F_IDLE;
      pix_addr_q <= '0;
      red_q      <= '0;
      tmr_q      <= '0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_addr_q <= pix_addr_d;
      red_q      <= red_d;
      tmr_q      <= tmr_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  logic in_frame, timed_out;
  assign in_frame  = (state_q == F_HI) || (state_q == F_LO);
  assign timed_out = (tmr_q == TMR_MAX);

  always_comb begin
    state_d    = state_q;
    pix_addr_d = pix_addr_q;
    red_d      = red_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    tmr_d      = '0;

    // Saturating inter-byte timer, restarted by every received byte.
    if (in_frame && !rx_valid) tmr_d = timed_out ? tmr_q : tmr_q + TMR_W'(1);

    unique case (state_q)
      F_IDLE: begin
        if (rx_valid && rx_shift_q == HDR_BYTE) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          pix_addr_d = '0;
          state_d    = F_HI;
        end
      end
      F_HI: begin
        if (rx_valid) begin
          if (rx_shift_q[7:4] == 4'd0) begin
            red_d   = rx_shift_q[3:0];
            state_d = F_LO;
          end else begin
            state_d = F_ABORT;
          end
        end else if (rx_ferr || timed_out) begin
          state_d = F_ABORT;
        end
      end
      F_LO: begin
        if (rx_valid) begin
          we_d      = 1'b1;
          wr_addr_d = pix_addr_q;
          wdata_d   = {red_q, rx_shift_q};
          if (pix_addr_q == ADDR_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = F_IDLE;
          end else begin
            pix_addr_d = pix_addr_q + 14'd1;
            state_d    = F_HI;
          end
        end else if (rx_ferr || timed_out) begin
          state_d = F_ABORT;
        end
      end
      F_ABORT: begin
        state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase

    // The error flag is raised on the abort event itself, one cycle after it is seen.
    if (state_d == F_ABORT || state_q == F_ABORT) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign O_ram.we    = we_q;
  assign O_ram.addr  = wr_addr_q;
  assign O_ram.wdata = wdata_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_err       = err_q;

endmodule

// File: tb/tb_img_uart_loader.sv
// Directed bench for img_uart_loader: serial frames in, RAM writes and status
// flags compared against hand-computed values.
module tb_img_uart_loader;
  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic busy, done, err;

  img_uart_loader_if ram ();

  img_uart_loader #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000),
    .PIX_NUM  (4),
    .HDR_BYTE (8'hA5),
    .TIMEOUT  (2000)
  ) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .I_rxd   (rxd),
    .O_ram   (ram),
    .O_busy  (busy),
    .O_done  (done),
    .O_err   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Write log, filled on the falling edge whenever the write strobe is high.
  int          wr_cnt = 0;
  logic [13:0] wr_addr [32];
  logic [11:0] wr_data [32];
  logic        wr_done [32];
  logic        wr_busy [32];

  always @(negedge clk) begin
    if (ram.we) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt] = ram.addr;
        wr_data[wr_cnt] = ram.wdata;
        wr_done[wr_cnt] = done;
        wr_busy[wr_cnt] = busy;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    cycles(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] bytes [9]);
    for (int i = 0; i < 9; i++) send_byte(bytes[i], 1'b1);
    cycles(2);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [11:0] exp [4]);
    check($sformatf("%s_wr_count", tag), wr_cnt - base, 4);
    if (wr_cnt - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_addr%0d", tag, i), wr_addr[base+i], i);
        check($sformatf("%s_data%0d", tag, i), wr_data[base+i], exp[i]);
      end
      check($sformatf("%s_done_first", tag), wr_done[base], 1'b0);
      check($sformatf("%s_done_last", tag), wr_done[base+3], 1'b1);
      check($sformatf("%s_busy_last", tag), wr_busy[base+3], 1'b0);
    end
    check($sformatf("%s_done", tag), done, 1'b1);
    check($sformatf("%s_busy", tag), busy, 1'b0);
    check($sformatf("%s_err", tag), err, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    cycles(4);
    rst_n = 1'b1;
    cycles(4);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0]  f1 [9] = '{8'hA5, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h0F, 8'h05, 8'hA3};
    logic [11:0] e1 [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h5A3};
    logic [7:0]  f5 [9] = '{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};
    logic [11:0] e5 [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
    logic [7:0]  f6 [9] = '{8'hA5, 8'h0C, 8'h01, 8'h0D, 8'h02, 8'h0E, 8'h03, 8'h0F, 8'h04};
    logic [11:0] e6 [4] = '{12'hC01, 12'hD02, 12'hE03, 12'hF04};

    // Reset values
    cycles(2);
    check("rst_outputs", {ram.we, ram.addr, ram.wdata, busy, done, err}, '0);
    rst_n = 1'b1;
    cycles(4);

    // 1: full frame
    base = wr_cnt;
    send_frame(f1);
    check_frame("t1", base, e1);

    // 2: bad upper nibble aborts after one write
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    cycles(1);
    check("t2_hdr_busy", busy, 1'b1);
    check("t2_hdr_done_clr", done, 1'b0);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3F, 1'b1);
    cycles(2);
    check("t2_wr_count", wr_cnt - base, 1);
    check("t2_addr0", wr_addr[base], 0);
    check("t2_data0", wr_data[base], 12'hF00);
    check("t2_err", err, 1'b1);
    check("t2_busy", busy, 1'b0);
    check("t2_done", done, 1'b0);
    send_byte(8'hA5, 1'b1);
    cycles(1);
    check("t2_rehdr_err", err, 1'b0);
    check("t2_rehdr_busy", busy, 1'b1);

    // 3: framing error mid-frame (continues the frame opened above)
    base = wr_cnt;
    send_byte(8'h0F, 1'b1);
    send_byte(8'h55, 1'b0);
    cycles(2);
    check("t3_no_write", wr_cnt - base, 0);
    check("t3_err", err, 1'b1);
    check("t3_busy", busy, 1'b0);
    send_byte(8'h0F, 1'b1);
    cycles(2);
    check("t3_idle_ignores", {busy, err}, 2'b01);

    // 4: inter-byte timeout
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0F, 1'b1);
    cycles(1900);
    check("t4_pre_timeout_busy", busy, 1'b1);
    check("t4_pre_timeout_err", err, 1'b0);
    cycles(200);
    check("t4_err", err, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_no_write", wr_cnt - base, 0);

    // 5: glitch and junk bytes in idle, then a valid frame
    do_reset();
    base = wr_cnt;
    rxd = 1'b0;
    cycles(5);
    rxd = 1'b1;
    cycles(40);
    check("t5_glitch_outs", {ram.we, busy, done, err}, 4'b0000);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    cycles(2);
    check("t5_junk_outs", {busy, done, err}, 3'b000);
    check("t5_junk_no_write", wr_cnt - base, 0);
    send_frame(f5);
    check_frame("t5", base, e5);

    // 6: asynchronous reset during the second pixel
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h04, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("t6_pre_busy", busy, 1'b1);
    check("t6_pre_wdata", ram.wdata, 12'h123);
    rst_n = 1'b0;
    #2;
    check("t6_async_outs", {ram.we, ram.addr, ram.wdata, busy, done, err}, '0);
    rxd = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    base = wr_cnt;
    send_frame(f6);
    check_frame("t6", base, e6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
